// File: rtl/ex_pipeline_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush, EX operand forwarding and multi-cycle EX hold.
// Define EX_PIPELINE_CTRL_FWD_EN to enable forwarding; otherwise every RAW hazard stalls until retired.
//
// state | meaning
// RUN   | normal issue, hazards resolved per cycle
// MC    | multi-cycle EX op in flight, front end held, MEM bubbled
// DONE  | EX result valid, stalls released for one cycle
module ex_pipeline_ctrl #(
  parameter int MC_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_use_i,
  input  logic       id_rs2_use_i,
  input  logic [4:0] ex_waddr_i,
  input  logic       ex_we_i,
  input  logic       ex_load_i,
  input  logic       ex_mc_start_i,
  input  logic [4:0] mem_waddr_i,
  input  logic       mem_we_i,
  input  logic [4:0] wb_waddr_i,
  input  logic       wb_we_i,
  input  logic       branch_taken_i,
  input  logic       exc_req_i,
  input  logic       imem_ready_i,
  input  logic       dmem_ready_i,
  output logic       if_stall_o,
  output logic       id_stall_o,
  output logic       ex_stall_o,
  output logic       mem_stall_o,
  output logic       if_flush_o,
  output logic       id_flush_o,
  output logic       ex_flush_o,
  output logic       mem_flush_o,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o,
  output logic       mc_busy_o
);

  typedef enum logic [1:0] {RUN, MC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic ex_match, mem_match, wb_match, load_use, hazard;

  assign ex_match  = ex_we_i && (ex_waddr_i != 5'd0) &&
                     ((id_rs1_use_i && (id_rs1_addr_i == ex_waddr_i)) ||
                      (id_rs2_use_i && (id_rs2_addr_i == ex_waddr_i)));
  assign mem_match = mem_we_i && (mem_waddr_i != 5'd0) &&
                     ((id_rs1_use_i && (id_rs1_addr_i == mem_waddr_i)) ||
                      (id_rs2_use_i && (id_rs2_addr_i == mem_waddr_i)));
  assign wb_match  = wb_we_i && (wb_waddr_i != 5'd0) &&
                     ((id_rs1_use_i && (id_rs1_addr_i == wb_waddr_i)) ||
                      (id_rs2_use_i && (id_rs2_addr_i == wb_waddr_i)));
  assign load_use  = ex_load_i && ex_match;

`ifdef EX_PIPELINE_CTRL_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_addr, input logic m_we,
                                         input logic [4:0] w_addr, input logic w_we);
    if (m_we && (m_addr != 5'd0) && (m_addr == src))
      return 2'd1;
    else if (w_we && (w_addr != 5'd0) && (w_addr == src))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  assign hazard      = load_use;
  assign fwd_a_sel_o = rst_i ? 2'd0 : fwd_sel(id_rs1_addr_i, mem_waddr_i, mem_we_i, wb_waddr_i, wb_we_i);
  assign fwd_b_sel_o = rst_i ? 2'd0 : fwd_sel(id_rs2_addr_i, mem_waddr_i, mem_we_i, wb_waddr_i, wb_we_i);
`else
  // Without bypass paths any in-flight producer must retire before ID may issue.
  assign hazard      = load_use || ex_match || mem_match || wb_match;
  assign fwd_a_sel_o = 2'd0;
  assign fwd_b_sel_o = 2'd0;
`endif

  always_comb begin
    if_stall_o  = 1'b0;
    id_stall_o  = 1'b0;
    ex_stall_o  = 1'b0;
    mem_stall_o = 1'b0;
    if_flush_o  = 1'b0;
    id_flush_o  = 1'b0;
    ex_flush_o  = 1'b0;
    mem_flush_o = 1'b0;
    if (rst_i || exc_req_i) begin
      if_flush_o  = 1'b1;
      id_flush_o  = 1'b1;
      ex_flush_o  = 1'b1;
      mem_flush_o = 1'b1;
    end else if (!dmem_ready_i) begin
      if_stall_o  = 1'b1;
      id_stall_o  = 1'b1;
      ex_stall_o  = 1'b1;
      mem_stall_o = 1'b1;
    end else if (state == MC) begin
      if_stall_o  = 1'b1;
      id_stall_o  = 1'b1;
      ex_stall_o  = 1'b1;
      mem_flush_o = 1'b1;
    end else if (hazard) begin
      if_stall_o  = 1'b1;
      id_stall_o  = 1'b1;
      ex_flush_o  = 1'b1;
    end else if (branch_taken_i) begin
      if_flush_o  = 1'b1;
      id_flush_o  = 1'b1;
    end else if (!imem_ready_i) begin
      if_stall_o  = 1'b1;
      id_flush_o  = 1'b1;
    end
  end

  // A data-bus wait freezes the sequencer so the op keeps its full latency.
  always_ff @(posedge clk_i) begin
    if (rst_i || exc_req_i) begin
      state     <= RUN;
      cnt       <= '0;
      mc_busy_o <= 1'b0;
    end else if (dmem_ready_i) begin
      case (state)
        RUN: begin
          if (ex_mc_start_i && !ex_flush_o) begin
            state     <= MC;
            cnt       <= CNT_W'(MC_LATENCY - 1);
            mc_busy_o <= 1'b1;
          end
        end
        MC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            mc_busy_o <= 1'b0;
          end
        end
        DONE: begin
          state <= RUN;
        end
        default: begin
          state     <= RUN;
          cnt       <= '0;
          mc_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_pipeline_ctrl.sv
// Directed bench for ex_pipeline_ctrl; expected control words are queued per step and checked mid-cycle.
module tb_ex_pipeline_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i;
  logic       id_rs1_use_i, id_rs2_use_i;
  logic [4:0] ex_waddr_i;
  logic       ex_we_i, ex_load_i, ex_mc_start_i;
  logic [4:0] mem_waddr_i;
  logic       mem_we_i;
  logic [4:0] wb_waddr_i;
  logic       wb_we_i;
  logic       branch_taken_i, exc_req_i, imem_ready_i, dmem_ready_i;
  logic       if_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
  logic       if_flush_o, id_flush_o, ex_flush_o, mem_flush_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic       mc_busy_o;

  ex_pipeline_ctrl #(.MC_LATENCY(4), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
    .ex_waddr_i(ex_waddr_i), .ex_we_i(ex_we_i), .ex_load_i(ex_load_i),
    .ex_mc_start_i(ex_mc_start_i),
    .mem_waddr_i(mem_waddr_i), .mem_we_i(mem_we_i),
    .wb_waddr_i(wb_waddr_i), .wb_we_i(wb_we_i),
    .branch_taken_i(branch_taken_i), .exc_req_i(exc_req_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .if_stall_o(if_stall_o), .id_stall_o(id_stall_o),
    .ex_stall_o(ex_stall_o), .mem_stall_o(mem_stall_o),
    .if_flush_o(if_flush_o), .id_flush_o(id_flush_o),
    .ex_flush_o(ex_flush_o), .mem_flush_o(mem_flush_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
    .mc_busy_o(mc_busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Word layout: {stall if,id,ex,mem | flush if,id,ex,mem | fwd_a | fwd_b | busy}
  typedef struct {
    string       tag;
    logic [12:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] S_NONE = 4'b0000, S_ALL = 4'b1111, S_IFID = 4'b1100,
                         S_IFIDEX = 4'b1110, S_IF = 4'b1000;
  localparam logic [3:0] F_NONE = 4'b0000, F_ALL = 4'b1111, F_EX = 4'b0010,
                         F_MEM = 4'b0001, F_IFID = 4'b1100, F_ID = 4'b0100;

  function automatic logic [12:0] w(input logic [3:0] st, input logic [3:0] fl,
                                    input logic [1:0] fa, input logic [1:0] fb,
                                    input logic busy);
    return {st, fl, fa, fb, busy};
  endfunction

  task automatic clr();
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
    id_rs1_use_i = 1'b0;  id_rs2_use_i = 1'b0;
    ex_waddr_i = 5'd0; ex_we_i = 1'b0; ex_load_i = 1'b0; ex_mc_start_i = 1'b0;
    mem_waddr_i = 5'd0; mem_we_i = 1'b0;
    wb_waddr_i = 5'd0; wb_we_i = 1'b0;
    branch_taken_i = 1'b0; exc_req_i = 1'b0;
    imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Push the expectation for the current inputs, compare mid-cycle, then advance one edge.
  task automatic step(input string tag, input logic [12:0] e);
    exp_t x;
    logic [12:0] obs;
    exp_q.push_back('{tag: tag, word: e});
    @(negedge clk_i);
    x = exp_q.pop_front();
    obs = {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o,
           if_flush_o, id_flush_o, ex_flush_o, mem_flush_o,
           fwd_a_sel_o, fwd_b_sel_o, mc_busy_o};
    checks++;
    assert (obs === x.word) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.word);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    rst_i = 1'b1;
    mem_waddr_i = 5'd5; mem_we_i = 1'b1; id_rs1_addr_i = 5'd5; id_rs1_use_i = 1'b1;
    tick();
    step("reset", w(S_NONE, F_ALL, 2'd0, 2'd0, 1'b0));
    rst_i = 1'b0; clr();
    step("idle", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));

`ifdef EX_PIPELINE_CTRL_FWD_EN
    ex_waddr_i = 5'd5; ex_we_i = 1'b1;
    step("fwd_prod_ex", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    clr(); mem_waddr_i = 5'd5; mem_we_i = 1'b1; id_rs1_addr_i = 5'd5; id_rs1_use_i = 1'b1;
    step("fwd_a_mem", w(S_NONE, F_NONE, 2'd1, 2'd0, 1'b0));
    clr(); wb_waddr_i = 5'd5; wb_we_i = 1'b1; id_rs1_addr_i = 5'd5; id_rs1_use_i = 1'b1;
    step("fwd_a_wb", w(S_NONE, F_NONE, 2'd2, 2'd0, 1'b0));
    clr(); mem_waddr_i = 5'd5; mem_we_i = 1'b1; wb_waddr_i = 5'd5; wb_we_i = 1'b1;
    id_rs1_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs1_use_i = 1'b1; id_rs2_use_i = 1'b1;
    step("fwd_double", w(S_NONE, F_NONE, 2'd1, 2'd1, 1'b0));
    clr(); mem_we_i = 1'b1; wb_we_i = 1'b1; id_rs1_use_i = 1'b1; id_rs2_use_i = 1'b1;
    step("fwd_x0", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
`else
    ex_waddr_i = 5'd3; ex_we_i = 1'b1; id_rs1_addr_i = 5'd3; id_rs1_use_i = 1'b1;
    step("raw_ex", w(S_IFID, F_EX, 2'd0, 2'd0, 1'b0));
    clr(); mem_waddr_i = 5'd3; mem_we_i = 1'b1; id_rs1_addr_i = 5'd3; id_rs1_use_i = 1'b1;
    step("raw_mem", w(S_IFID, F_EX, 2'd0, 2'd0, 1'b0));
    clr(); wb_waddr_i = 5'd3; wb_we_i = 1'b1; id_rs1_addr_i = 5'd3; id_rs1_use_i = 1'b1;
    step("raw_wb", w(S_IFID, F_EX, 2'd0, 2'd0, 1'b0));
    clr(); id_rs1_addr_i = 5'd3; id_rs1_use_i = 1'b1;
    step("raw_retired", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    clr(); ex_waddr_i = 5'd3; ex_we_i = 1'b1; id_rs1_addr_i = 5'd3;
    step("raw_unused_src", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    clr(); ex_we_i = 1'b1; id_rs1_use_i = 1'b1; mem_we_i = 1'b1;
    step("raw_x0", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
`endif

    clr(); ex_load_i = 1'b1; ex_we_i = 1'b1; ex_waddr_i = 5'd7;
    id_rs2_addr_i = 5'd7; id_rs2_use_i = 1'b1;
    step("load_use", w(S_IFID, F_EX, 2'd0, 2'd0, 1'b0));
    clr(); mem_waddr_i = 5'd7; mem_we_i = 1'b1; id_rs2_addr_i = 5'd7; id_rs2_use_i = 1'b1;
`ifdef EX_PIPELINE_CTRL_FWD_EN
    step("load_use_after", w(S_NONE, F_NONE, 2'd0, 2'd1, 1'b0));
`else
    step("load_use_after", w(S_IFID, F_EX, 2'd0, 2'd0, 1'b0));
`endif

    clr(); ex_load_i = 1'b1; ex_we_i = 1'b1; ex_waddr_i = 5'd9;
    id_rs1_addr_i = 5'd9; id_rs1_use_i = 1'b1; branch_taken_i = 1'b1;
    step("load_use_vs_branch", w(S_IFID, F_EX, 2'd0, 2'd0, 1'b0));
    clr(); branch_taken_i = 1'b1;
    step("branch", w(S_NONE, F_IFID, 2'd0, 2'd0, 1'b0));
    clr(); imem_ready_i = 1'b0;
    step("imem_wait", w(S_IF, F_ID, 2'd0, 2'd0, 1'b0));
    branch_taken_i = 1'b1;
    step("branch_vs_imem", w(S_NONE, F_IFID, 2'd0, 2'd0, 1'b0));
    clr(); dmem_ready_i = 1'b0;
    step("dmem_wait", w(S_ALL, F_NONE, 2'd0, 2'd0, 1'b0));
    exc_req_i = 1'b1; branch_taken_i = 1'b1;
    step("exc_vs_dmem", w(S_NONE, F_ALL, 2'd0, 2'd0, 1'b0));

    // Plain multi-cycle op: 3 busy cycles then the DONE release
    clr(); ex_mc_start_i = 1'b1;
    step("mc_start", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    ex_mc_start_i = 1'b0;
    step("mc_1", w(S_IFIDEX, F_MEM, 2'd0, 2'd0, 1'b1));
    branch_taken_i = 1'b1;
    step("mc_2_branch", w(S_IFIDEX, F_MEM, 2'd0, 2'd0, 1'b1));
    branch_taken_i = 1'b0;
    step("mc_3", w(S_IFIDEX, F_MEM, 2'd0, 2'd0, 1'b1));
    ex_mc_start_i = 1'b1;
    step("mc_done", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    ex_mc_start_i = 1'b0;
    step("mc_after_done", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));

    // Data-bus wait mid-op extends busy by its length
    ex_mc_start_i = 1'b1;
    step("mcd_start", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    ex_mc_start_i = 1'b0;
    step("mcd_1", w(S_IFIDEX, F_MEM, 2'd0, 2'd0, 1'b1));
    dmem_ready_i = 1'b0;
    step("mcd_wait_1", w(S_ALL, F_NONE, 2'd0, 2'd0, 1'b1));
    step("mcd_wait_2", w(S_ALL, F_NONE, 2'd0, 2'd0, 1'b1));
    dmem_ready_i = 1'b1;
    step("mcd_2", w(S_IFIDEX, F_MEM, 2'd0, 2'd0, 1'b1));
    step("mcd_3", w(S_IFIDEX, F_MEM, 2'd0, 2'd0, 1'b1));
    step("mcd_done", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));

    // Exception aborts an op in MC
    ex_mc_start_i = 1'b1;
    step("mce_start", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    ex_mc_start_i = 1'b0;
    step("mce_1", w(S_IFIDEX, F_MEM, 2'd0, 2'd0, 1'b1));
    exc_req_i = 1'b1;
    step("mce_exc", w(S_NONE, F_ALL, 2'd0, 2'd0, 1'b1));
    exc_req_i = 1'b0;
    step("mce_run", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));

    // Exception on the DONE cycle
    ex_mc_start_i = 1'b1;
    step("mcx_start", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    ex_mc_start_i = 1'b0;
    for (int i = 0; i < 3; i++)
      step("mcx_busy", w(S_IFIDEX, F_MEM, 2'd0, 2'd0, 1'b1));
    exc_req_i = 1'b1;
    step("mcx_done_exc", w(S_NONE, F_ALL, 2'd0, 2'd0, 1'b0));
    exc_req_i = 1'b0;
    step("mcx_run", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));

    // Reset mid-op: no DONE, busy cleared
    ex_mc_start_i = 1'b1;
    step("mcr_start", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    ex_mc_start_i = 1'b0;
    step("mcr_1", w(S_IFIDEX, F_MEM, 2'd0, 2'd0, 1'b1));
    rst_i = 1'b1;
    tick();
    step("mcr_reset", w(S_NONE, F_ALL, 2'd0, 2'd0, 1'b0));
    rst_i = 1'b0;
    step("mcr_run_1", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));
    step("mcr_run_2", w(S_NONE, F_NONE, 2'd0, 2'd0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_pipeline_ctrl.md
# ex_pipeline_ctrl

Pipeline sequencing controller for the five-stage core.
- Owns every stage's stall and flush line: IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Selects the EX forwarding sources for the ALU operand ports.
- Holds the pipeline while a multi-cycle EX operation runs.
- Resolves competing hazard, branch, memory-wait and exception events into one consistent per-cycle control word.

## Interface

Parameters:
- MC_LATENCY, 32, cycles a multi-cycle EX operation occupies (>=2)
- CNT_W, 6, counter width; must satisfy 2^CNT_W > MC_LATENCY

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- id_rs1_addr_i / id_rs2_addr_i  in  5 each  source registers of the instruction in ID
- id_rs1_use_i / id_rs2_use_i  in  1 each  ID instruction actually reads rs1 / rs2
- ex_waddr_i  in  5  EX destination register
- ex_we_i  in  1  EX writes the register file
- ex_load_i  in  1  EX instruction is a load
- ex_mc_start_i  in  1  EX instruction is multi-cycle (mul/div)
- mem_waddr_i, mem_we_i  in  5, 1  MEM destination and write enable
- wb_waddr_i, wb_we_i  in  5, 1  WB destination and write enable
- branch_taken_i  in  1  branch/jump resolved taken in EX
- exc_req_i  in  1  exception or trap raised in MEM
- imem_ready_i / dmem_ready_i  in  1 each  instruction / data bus ready
- if_stall_o, id_stall_o, ex_stall_o, mem_stall_o  out  1 each  hold the stage register
- if_flush_o, id_flush_o, ex_flush_o, mem_flush_o  out  1 each  bubble the stage register
- fwd_a_sel_o / fwd_b_sel_o  out  2 each  operand source: 0 = RF, 1 = EX/MEM, 2 = MEM/WB, 3 = reserved
- mc_busy_o  out  1  multi-cycle operation in progress

## Operation

State machine for the multi-cycle sequencer, with a down-counter `cnt`:
- **RUN**: normal operation.
  - `ex_mc_start_i=1` and no flush of EX this cycle -> go to **MC**, load `cnt = MC_LATENCY-1`.
- **MC**: `mc_busy_o=1`.
  - Stall IF, ID and EX; bubble MEM (`mem_flush_o=1`).
  - `cnt` decrements each cycle.
  - When `cnt==1`, go to **DONE**.
- **DONE**: EX result is valid.
  - Release the stalls for one cycle so EX advances.
  - Ignore `ex_mc_start_i` this cycle.
  - Return to **RUN**.
- `exc_req_i` in **MC** or **DONE** -> abort to **RUN**; `cnt` cleared.

Per-cycle priority, highest first:
1. `exc_req_i`
   - Flush IF/ID/EX/MEM; no stalls.
   - Overrides every other event, including `dmem_ready_i=0`.
2. `dmem_ready_i=0`
   - Stall all four stages; no flushes.
   - The FSM freezes: `cnt` holds its value.
3. FSM in **MC**
   - Stall pattern as given under **MC** above.
4. Load-use hazard: `ex_load_i & ex_we_i & ex_waddr_i!=0` and the EX destination matches a used ID source.
   - Stall IF and ID; flush EX (insert bubble).
5. `branch_taken_i`
   - Flush IF and ID; no stalls.
6. `imem_ready_i=0`
   - Stall IF; flush ID.

Forwarding, evaluated per operand and combinational:
- Select 1 when the MEM stage writes a nonzero register matching the source.
- Otherwise select 2 when the WB stage does.
- Otherwise select 0.
- Register x0 never forwards.
- MEM takes precedence over WB on a double match.

## Timing

- All stall, flush and forwarding outputs are combinational from the inputs and the registered FSM state; they act at the next `clk_i` edge.
- FSM state and `cnt` update only on `clk_i`.
- Multi-cycle op: `ex_mc_start_i` sampled at edge N.
  - `mc_busy_o` is high for cycles N+1 .. N+MC_LATENCY-1.
  - The result advances at the edge ending the **DONE** cycle.
- Load-use costs exactly one bubble; branch costs exactly two flushed slots.

Reset (`rst_i=1` at an edge):
- FSM returns to **RUN**; `cnt=0`; `mc_busy_o=0`.
- While `rst_i` is high, all flush outputs are forced to 1 and all stalls to 0.
- `fwd_*_sel_o` are forced to 0.
- Reset mid-**MC** aborts the operation with no **DONE** cycle.

Boundary cases:
- Branch and load-use in the same cycle: load-use wins; the branch re-resolves the next cycle.
- `exc_req_i` on the same edge as **DONE**: the EX result is discarded.

## Configuration

Macro `EX_PIPELINE_CTRL_FWD_EN`.

Defined:
- Forwarding as described above.
- Only load-use stalls are inserted.

Undefined:
- `fwd_a_sel_o` and `fwd_b_sel_o` are tied to 0.
- Any used ID source matching a nonzero, writing destination in EX, MEM or WB stalls IF and ID and flushes EX.
- This RAW stall repeats each cycle until the match clears.
- Priority slot 4 covers this RAW stall.

## Test plan

- Reset, then all-idle inputs -> all stalls 0, all flushes 0, `fwd_*_sel_o=0`, `mc_busy_o=0`.
- EX writes x5 and is not a load; ID reads x5 next cycle -> `fwd_a_sel_o=1`; x5 in WB only -> 2; x0 in MEM and WB -> 0.
- EX `ex_load_i=1`, waddr=7; ID rs2=7 used -> exactly one cycle of `if_stall_o=id_stall_o=ex_flush_o=1`.
- `ex_mc_start_i` with MC_LATENCY=4 -> `mc_busy_o` high for 3 cycles, then the **DONE** release; `dmem_ready_i=0` for 2 cycles mid-op extends busy by 2.
- `exc_req_i` during **MC** -> all four flushes high that cycle, FSM in **RUN** next cycle, `mc_busy_o=0`.
- Macro undefined: EX writes x3, ID reads x3 -> stall for 3 cycles until WB retires, `fwd_*_sel_o=0` throughout.
